// File: rtl/mealy_ring_pkg.sv
// Shared constants and one-hot helpers for the ring sequencer.
// Vectors are handled at MAX_STATES width; callers slice down to NUM_STATES.
package mealy_ring_pkg;

    localparam int   MAX_STATES = 64;
    localparam logic DIR_CW     = 1'b0;
    localparam logic DIR_CCW    = 1'b1;

    typedef logic [MAX_STATES-1:0] ring_vec_t;

    // An out-of-range index gives all-zero, so callers can detect it and substitute.
    function automatic ring_vec_t onehot(input int unsigned idx, input int unsigned n);
        ring_vec_t one;
        one = ring_vec_t'(1);
        return (idx < n) ? (one << idx) : '0;
    endfunction

    function automatic logic is_onehot(input ring_vec_t vec);
        return $onehot(vec);
    endfunction

endpackage

// File: rtl/mealy_ring_next.sv
// Combinational next-state, wrap and illegal-state decode for the one-hot ring.
// Priority: illegal recovery, then load, then step, then hold.
module mealy_ring_next
    import mealy_ring_pkg::*;
#(
    parameter int NUM_STATES = 3,
    parameter int RESET_IDX  = 0,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_STATES-1:0] i_state,
    input  logic                  i_step,
    input  logic                  i_dir,
    input  logic                  i_load,
    input  logic [IDX_W-1:0]      i_load_idx,
    output logic [NUM_STATES-1:0] o_n_state,
    output logic                  o_wrap,
    output logic                  o_illegal
);

    localparam ring_vec_t                 RST_FULL = onehot(RESET_IDX, NUM_STATES);
    localparam logic [NUM_STATES-1:0]     RST_OH   = RST_FULL[NUM_STATES-1:0];

    ring_vec_t             w_load_full;
    logic [NUM_STATES-1:0] w_load_oh;
    logic [NUM_STATES-1:0] w_rot_cw;
    logic [NUM_STATES-1:0] w_rot_ccw;
    logic                  w_illegal;

    assign w_load_full = onehot(32'(i_load_idx), NUM_STATES);
    assign w_load_oh   = (32'(i_load_idx) < NUM_STATES) ? w_load_full[NUM_STATES-1:0] : RST_OH;
    assign w_rot_cw    = {i_state[NUM_STATES-2:0], i_state[NUM_STATES-1]};
    assign w_rot_ccw   = {i_state[0], i_state[NUM_STATES-1:1]};
    assign w_illegal   = !is_onehot(ring_vec_t'(i_state));

    always_comb begin
        o_n_state = i_state;
        o_wrap    = 1'b0;
        o_illegal = w_illegal;
        if (w_illegal) begin
            o_n_state = RST_OH;
        end else if (i_load) begin
            o_n_state = w_load_oh;
        end else if (i_step) begin
            // A legal state is one-hot, so the end bit alone tells us we cross the seam.
            if (i_dir == DIR_CW) begin
                o_n_state = w_rot_cw;
                o_wrap    = i_state[NUM_STATES-1];
            end else begin
                o_n_state = w_rot_ccw;
                o_wrap    = i_state[0];
            end
        end
    end

endmodule

// File: rtl/mealy_ring_fsm.sv
// One-hot ring sequencer with Mealy z/wrap outputs and a wrap-around lap counter.
// Optional sticky illegal-state flag err_out when MEALY_RING_ERR_EN is defined.
module mealy_ring_fsm
    import mealy_ring_pkg::*;
#(
    parameter  int NUM_STATES = 3,
    parameter  int LAP_W      = 4,
    parameter  int RESET_IDX  = 0,
    localparam int IDX_W      = ($clog2(NUM_STATES) < 1) ? 1 : $clog2(NUM_STATES)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  step_in,
    input  logic                  dir_in,
    input  logic                  load_in,
    input  logic [IDX_W-1:0]      load_idx,
    output logic [NUM_STATES-1:0] state_out,
    output logic [NUM_STATES-1:0] z_out,
    output logic                  wrap_out,
    output logic [LAP_W-1:0]      lap_out
`ifdef MEALY_RING_ERR_EN
    ,
    output logic                  err_out
`endif
);

    localparam ring_vec_t             RST_FULL = onehot(RESET_IDX, NUM_STATES);
    localparam logic [NUM_STATES-1:0] RST_OH   = RST_FULL[NUM_STATES-1:0];

    logic [NUM_STATES-1:0] r_state;
    logic [LAP_W-1:0]      r_lap;
    logic [NUM_STATES-1:0] w_n_state;
    logic                  w_wrap;
    logic                  w_illegal;

    mealy_ring_next #(
        .NUM_STATES (NUM_STATES),
        .RESET_IDX  (RESET_IDX),
        .IDX_W      (IDX_W)
    ) u_next (
        .i_state    (r_state),
        .i_step     (step_in),
        .i_dir      (dir_in),
        .i_load     (load_in),
        .i_load_idx (load_idx),
        .o_n_state  (w_n_state),
        .o_wrap     (w_wrap),
        .o_illegal  (w_illegal)
    );

`ifdef MEALY_RING_ERR_EN
    logic r_err;

    // Recovery beats a coincident load, so the flag is set rather than cleared then.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end else if (load_in) begin
            r_err <= 1'b0;
        end
    end

    assign err_out = r_err;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RST_OH;
            r_lap   <= '0;
        end else begin
            r_state <= w_n_state;
            if (w_wrap) begin
                r_lap <= r_lap + 1'b1;
            end
        end
    end

    assign state_out = r_state;
    assign lap_out   = r_lap;
    assign wrap_out  = w_wrap;
    assign z_out     = w_illegal ? '0 : (r_state | w_n_state);

endmodule

// File: tb/tb_mealy_ring_fsm.sv
// Bench for mealy_ring_fsm: directed table, illegal/reset corners, random vs index model,
// and a 5-state ring with a 2-bit lap counter for rollover.
module tb_mealy_ring_fsm;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic       s3_step, s3_dir, s3_load;
    logic [1:0] s3_idx;
    logic [2:0] s3_state, s3_z;
    logic       s3_wrap;
    logic [3:0] s3_lap;

    logic       s5_step, s5_dir, s5_load;
    logic [2:0] s5_idx;
    logic [4:0] s5_state, s5_z;
    logic       s5_wrap;
    logic [1:0] s5_lap;

`ifdef MEALY_RING_ERR_EN
    logic s3_err, s5_err;
`endif

    mealy_ring_fsm #(.NUM_STATES(3), .LAP_W(4), .RESET_IDX(0)) dut3 (
        .clock(clock), .reset_n(reset_n), .step_in(s3_step), .dir_in(s3_dir),
        .load_in(s3_load), .load_idx(s3_idx), .state_out(s3_state), .z_out(s3_z),
        .wrap_out(s3_wrap), .lap_out(s3_lap)
`ifdef MEALY_RING_ERR_EN
        , .err_out(s3_err)
`endif
    );

    mealy_ring_fsm #(.NUM_STATES(5), .LAP_W(2), .RESET_IDX(0)) dut5 (
        .clock(clock), .reset_n(reset_n), .step_in(s5_step), .dir_in(s5_dir),
        .load_in(s5_load), .load_idx(s5_idx), .state_out(s5_state), .z_out(s5_z),
        .wrap_out(s5_wrap), .lap_out(s5_lap)
`ifdef MEALY_RING_ERR_EN
        , .err_out(s5_err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Drive one cycle on dut3, check the Mealy outputs before the edge and registers after.
    task automatic apply3(input string tag, input logic st, input logic dr, input logic ld,
                          input logic [1:0] li, input logic [2:0] ez, input logic ew,
                          input logic [2:0] es, input logic [3:0] el);
        @(negedge clock);
        s3_step = st; s3_dir = dr; s3_load = ld; s3_idx = li;
        #1;
        check({tag, "_z"},    32'(s3_z),    32'(ez));
        check({tag, "_wrap"}, 32'(s3_wrap), 32'(ew));
        @(posedge clock);
        #1;
        check({tag, "_state"}, 32'(s3_state), 32'(es));
        check({tag, "_lap"},   32'(s3_lap),   32'(el));
    endtask

    // Reference: position on the ring as an integer index.
    function automatic int model_next(input int idx, input int n, input logic st, input logic dr,
                                      input logic ld, input int li);
        if (ld)       return (li < n) ? li : 0;
        else if (!st) return idx;
        else if (dr)  return (idx + n - 1) % n;
        else          return (idx + 1) % n;
    endfunction

    typedef struct {
        logic       st, dr, ld;
        logic [1:0] li;
        logic [2:0] ez;
        logic       ew;
        logic [2:0] es;
        logic [3:0] el;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   m_idx, m_lap, nidx;
        logic m_err, ew;

        tbl = '{
            '{1'b1,1'b0,1'b0,2'd0,3'b011,1'b0,3'b010,4'd0},
            '{1'b1,1'b0,1'b0,2'd0,3'b110,1'b0,3'b100,4'd0},
            '{1'b1,1'b0,1'b0,2'd0,3'b101,1'b1,3'b001,4'd1},
            '{1'b1,1'b0,1'b0,2'd0,3'b011,1'b0,3'b010,4'd1},
            '{1'b1,1'b0,1'b0,2'd0,3'b110,1'b0,3'b100,4'd1},
            '{1'b1,1'b0,1'b0,2'd0,3'b101,1'b1,3'b001,4'd2},
            '{1'b1,1'b1,1'b0,2'd0,3'b101,1'b1,3'b100,4'd3},
            '{1'b1,1'b0,1'b1,2'd2,3'b100,1'b0,3'b100,4'd3},
            '{1'b1,1'b0,1'b1,2'd3,3'b101,1'b0,3'b001,4'd3},
            '{1'b1,1'b0,1'b0,2'd0,3'b011,1'b0,3'b010,4'd3},
            '{1'b0,1'b0,1'b0,2'd0,3'b010,1'b0,3'b010,4'd3},
            '{1'b0,1'b1,1'b0,2'd0,3'b010,1'b0,3'b010,4'd3},
            '{1'b0,1'b0,1'b0,2'd3,3'b010,1'b0,3'b010,4'd3},
            '{1'b0,1'b1,1'b0,2'd1,3'b010,1'b0,3'b010,4'd3},
            '{1'b1,1'b1,1'b0,2'd0,3'b011,1'b0,3'b001,4'd3},
            '{1'b1,1'b1,1'b0,2'd0,3'b101,1'b1,3'b100,4'd4},
            '{1'b0,1'b0,1'b1,2'd0,3'b101,1'b0,3'b001,4'd4},
            '{1'b1,1'b1,1'b1,2'd1,3'b011,1'b0,3'b010,4'd4}
        };

        reset_n = 1'b0;
        s3_step = 1'b0; s3_dir = 1'b0; s3_load = 1'b0; s3_idx = 2'd0;
        s5_step = 1'b0; s5_dir = 1'b0; s5_load = 1'b0; s5_idx = 3'd0;
        #12;
        check("rst_state3", 32'(s3_state), 32'h1);
        check("rst_lap3",   32'(s3_lap),   32'h0);
        check("rst_z3",     32'(s3_z),     32'h1);
        check("rst_state5", 32'(s5_state), 32'h01);
`ifdef MEALY_RING_ERR_EN
        check("rst_err3",   32'(s3_err),   32'h0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++)
            apply3($sformatf("tbl%0d", i), tbl[i].st, tbl[i].dr, tbl[i].ld, tbl[i].li,
                   tbl[i].ez, tbl[i].ew, tbl[i].es, tbl[i].el);

        // Illegal 011 with a CW step requested: outputs suppressed, recovery to reset state.
        @(negedge clock);
        s3_step = 1'b1; s3_dir = 1'b0; s3_load = 1'b0; s3_idx = 2'd0;
        force dut3.r_state = 3'b011;
        #1 release dut3.r_state;
        #1;
        check("ill_z",    32'(s3_z),    32'h0);
        check("ill_wrap", 32'(s3_wrap), 32'h0);
        @(posedge clock);
        #1;
        check("ill_recover", 32'(s3_state), 32'h1);
        check("ill_lap",     32'(s3_lap),   32'h4);
`ifdef MEALY_RING_ERR_EN
        check("ill_err_set", 32'(s3_err), 32'h1);
`endif
        apply3("ill_step", 1'b1, 1'b0, 1'b0, 2'd0, 3'b011, 1'b0, 3'b010, 4'd4);
`ifdef MEALY_RING_ERR_EN
        check("ill_err_sticky", 32'(s3_err), 32'h1);
`endif
        apply3("ill_load", 1'b0, 1'b0, 1'b1, 2'd0, 3'b011, 1'b0, 3'b001, 4'd4);
`ifdef MEALY_RING_ERR_EN
        check("ill_err_clr", 32'(s3_err), 32'h0);
`endif

        // Illegal state coinciding with a load: recovery wins.
        @(negedge clock);
        s3_step = 1'b0; s3_load = 1'b1; s3_idx = 2'd2;
        force dut3.r_state = 3'b110;
        #1 release dut3.r_state;
        #1;
        check("coin_z", 32'(s3_z), 32'h0);
        @(posedge clock);
        #1;
        check("coin_state", 32'(s3_state), 32'h1);
`ifdef MEALY_RING_ERR_EN
        check("coin_err", 32'(s3_err), 32'h1);
`endif

        // Asynchronous reset mid-cycle while stepping CW.
        @(negedge clock);
        s3_step = 1'b1; s3_dir = 1'b0; s3_load = 1'b0;
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_state", 32'(s3_state), 32'h1);
        check("arst_lap",   32'(s3_lap),   32'h0);
        check("arst_z",     32'(s3_z),     32'h3);
`ifdef MEALY_RING_ERR_EN
        check("arst_err",   32'(s3_err),   32'h0);
`endif
        @(negedge clock);
        s3_step = 1'b0;
        reset_n = 1'b1;

        m_idx = 0; m_lap = 0; m_err = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            s3_step = ($urandom_range(0, 9) < 7);
            s3_dir  = 1'($urandom_range(0, 1));
            s3_load = ($urandom_range(0, 9) == 0);
            s3_idx  = 2'($urandom_range(0, 3));
            nidx = model_next(m_idx, 3, s3_step, s3_dir, s3_load, int'(s3_idx));
            ew = s3_step && !s3_load && (s3_dir ? (nidx > m_idx) : (nidx < m_idx));
            #1;
            check($sformatf("rnd%0d_z", c),    32'(s3_z),    (32'h1 << m_idx) | (32'h1 << nidx));
            check($sformatf("rnd%0d_wrap", c), 32'(s3_wrap), 32'(ew));
            if (s3_load) m_err = 1'b0;
            @(posedge clock);
            #1;
            m_idx = nidx;
            if (ew) m_lap = (m_lap + 1) % 16;
            check($sformatf("rnd%0d_state", c), 32'(s3_state), 32'h1 << m_idx);
            check($sformatf("rnd%0d_lap", c),   32'(s3_lap),   32'(m_lap));
`ifdef MEALY_RING_ERR_EN
            check($sformatf("rnd%0d_err", c),   32'(s3_err),   32'(m_err));
`endif
        end

        // 5-state ring, 2-bit lap: 20 CW edges make 4 wraps, lap rolls 3 -> 0.
        m_idx = 0; m_lap = 0;
        for (int e = 0; e < 20; e++) begin
            @(negedge clock);
            s5_step = 1'b1; s5_dir = 1'b0; s5_load = 1'b0;
            nidx = model_next(m_idx, 5, 1'b1, 1'b0, 1'b0, 0);
            ew = (nidx < m_idx);
            #1;
            check($sformatf("r5_%0d_wrap", e), 32'(s5_wrap), 32'(ew));
            @(posedge clock);
            #1;
            m_idx = nidx;
            if (ew) m_lap = (m_lap + 1) % 4;
            check($sformatf("r5_%0d_state", e), 32'(s5_state), 32'h1 << m_idx);
            check($sformatf("r5_%0d_lap", e),   32'(s5_lap),   32'(m_lap));
        end
        check("r5_rollover", 32'(s5_lap), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
